// File: rtl/tpu_pkg.sv
// Shared defaults, memory map and controller states for the tpu_v1 matrix-multiply accelerator.
package tpu_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;
  localparam int DEF_ADDRW   = 16;
  localparam int DEF_DATAW   = 64;

  localparam logic [15:0] A_BASE      = 16'h0100;
  localparam logic [15:0] B_BASE      = 16'h0200;
  localparam logic [15:0] C_BASE      = 16'h0300;
  localparam logic [15:0] START_ADDR  = 16'h0400;
  localparam logic [15:0] STATUS_ADDR = 16'h0400;
  localparam logic [15:0] COUNT_ADDR  = 16'h0408;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/tpu_systolic_array.sv
// DIM x DIM output-stationary systolic array: A flows right, B flows down, each PE owns one C element.
// tpu_pe is the per-element MAC; the array keeps the operand forwarding registers between PEs.
module tpu_pe import tpu_pkg::*; #(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_ld,
  input  logic [BITS_C-1:0]  i_ld_val,
  input  logic [BITS_AB-1:0] i_a,
  input  logic [BITS_AB-1:0] i_b,
  output logic [BITS_C-1:0]  o_acc
);
  logic signed [2*BITS_AB-1:0] w_prod;
  logic        [BITS_C-1:0]    r_acc;

  assign w_prod = (2*BITS_AB)'($signed(i_a)) * (2*BITS_AB)'($signed(i_b));

  // Accumulation wraps; host loads only happen while the array is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_acc <= '0;
    else if (i_ld) r_acc <= i_ld_val;
    else if (i_en) r_acc <= r_acc + BITS_C'(w_prod);
  end

  assign o_acc = r_acc;
endmodule

module tpu_systolic_array import tpu_pkg::*; #(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_en,
  input  logic [DIM-1:0][BITS_AB-1:0]           i_a_left,
  input  logic [DIM-1:0][BITS_AB-1:0]           i_b_top,
  input  logic [DIM-1:0][DIM-1:0]               i_ld_we,
  input  logic [DIM-1:0][BITS_C-1:0]            i_ld_data,
  output logic [DIM-1:0][DIM-1:0][BITS_C-1:0]   o_c
);
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] w_a;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] w_b;
  logic [DIM-1:0][DIM-2:0][BITS_AB-1:0] r_ah;
  logic [DIM-2:0][DIM-1:0][BITS_AB-1:0] r_bv;

  // Forwarding regs flush to zero when idle so a new run starts from a clean pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ah <= '0;
      r_bv <= '0;
    end else begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM-1; c++)
          r_ah[r][c] <= i_en ? w_a[r][c] : '0;
      for (int r = 0; r < DIM-1; r++)
        for (int c = 0; c < DIM; c++)
          r_bv[r][c] <= i_en ? w_b[r][c] : '0;
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      if (c == 0) begin : g_al
        assign w_a[r][c] = i_a_left[r];
      end else begin : g_ai
        assign w_a[r][c] = r_ah[r][c-1];
      end
      if (r == 0) begin : g_bt
        assign w_b[r][c] = i_b_top[c];
      end else begin : g_bi
        assign w_b[r][c] = r_bv[r-1][c];
      end

      tpu_pe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (i_en),
        .i_ld     (i_ld_we[r][c]),
        .i_ld_val (i_ld_data[c]),
        .i_a      (w_a[r][c]),
        .i_b      (w_b[r][c]),
        .o_acc    (o_c[r][c])
      );
    end
  end
endmodule

// File: rtl/tpu_v1.sv
// tpu_v1 top: MMIO decode, A/B row buffers, skewed operand feed and the run controller.
// Optional TPU_STATUS_EN exposes busy at 0x400 and a completed-compute counter at 0x408.
module tpu_v1 import tpu_pkg::*; #(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM,
  parameter int ADDRW   = DEF_ADDRW,
  parameter int DATAW   = DEF_DATAW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_w,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] dataIn,
  output logic [DATAW-1:0] dataOut
);
  localparam int CL = DATAW / BITS_C;
  localparam int LW = $clog2(CL);
  localparam int AW = $clog2(DIM);
  localparam int TW = $clog2(3*DIM);
  localparam logic [ADDRW-1:0] LA    = ADDRW'(A_BASE);
  localparam logic [ADDRW-1:0] LB    = ADDRW'(B_BASE);
  localparam logic [ADDRW-1:0] LC    = ADDRW'(C_BASE);
  localparam logic [ADDRW-1:0] LS    = ADDRW'(START_ADDR);

  state_t r_state, w_state_nxt;
  logic [TW-1:0] r_t, w_t_nxt;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] r_a, r_b;
  logic [DIM-1:0][BITS_AB-1:0]          w_a_left, w_b_top;
  logic [DIM-1:0][DIM-1:0]              w_ld_we;
  logic [DIM-1:0][BITS_C-1:0]           w_ld_data;
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0]  w_c;
  logic          w_busy, w_wr_ok, w_start, w_a_hit, w_b_hit, w_c_hit, w_c_half;
  logic [AW-1:0] w_ab_row, w_c_row;

  // Decode: 8-byte aligned rows for A/B, two words per C row.
  assign w_busy   = (r_state != IDLE);
  assign w_wr_ok  = r_w && !w_busy;
  assign w_a_hit  = ((addr >> (AW+3)) == (LA >> (AW+3))) && (addr[2:0] == 3'b0);
  assign w_b_hit  = ((addr >> (AW+3)) == (LB >> (AW+3))) && (addr[2:0] == 3'b0);
  assign w_c_hit  = ((addr >> (AW+4)) == (LC >> (AW+4))) && (addr[2:0] == 3'b0);
  assign w_ab_row = addr[AW+2:3];
  assign w_c_row  = addr[AW+3:4];
  assign w_c_half = addr[3];
  assign w_start  = w_wr_ok && (addr == LS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_wr_ok && w_a_hit) r_a[w_ab_row] <= dataIn;
      if (w_wr_ok && w_b_hit) r_b[w_ab_row] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // RUN covers the 2*DIM-1 skewed feed slots, DRAIN lets the far corner finish.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = RUN;
          w_t_nxt     = '0;
        end
      end
      RUN: begin
        w_t_nxt = r_t + 1'b1;
        if (r_t == TW'(2*DIM-2)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_t == TW'(3*DIM-2)) begin
          w_state_nxt = IDLE;
          w_t_nxt     = '0;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Row g of A and column g of B enter g cycles late; k = t - g.
  for (genvar g = 0; g < DIM; g++) begin : g_feed
    logic [TW-1:0] w_k;
    logic          w_kv;
    assign w_k         = r_t - TW'(g);
    assign w_kv        = (r_t >= TW'(g)) && (w_k < TW'(DIM));
    assign w_a_left[g] = w_kv ? r_a[g][w_k[AW-1:0]] : '0;
    assign w_b_top[g]  = w_kv ? r_b[w_k[AW-1:0]][g] : '0;
  end

  for (genvar r = 0; r < DIM; r++) begin : g_ldr
    for (genvar c = 0; c < DIM; c++) begin : g_ldc
      assign w_ld_we[r][c] = w_wr_ok && w_c_hit && (w_c_row == AW'(r)) && (w_c_half == 1'(c / CL));
    end
  end

  for (genvar c = 0; c < DIM; c++) begin : g_ldd
    assign w_ld_data[c] = dataIn[(c % CL)*BITS_C +: BITS_C];
  end

  tpu_systolic_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_busy),
    .i_a_left  (w_a_left),
    .i_b_top   (w_b_top),
    .i_ld_we   (w_ld_we),
    .i_ld_data (w_ld_data),
    .o_c       (w_c)
  );

`ifdef TPU_STATUS_EN
  localparam logic [ADDRW-1:0] LCNT = ADDRW'(COUNT_ADDR);
  logic [31:0] r_done_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done_cnt <= '0;
    else if (r_state == DRAIN && r_t == TW'(3*DIM-2)) r_done_cnt <= r_done_cnt + 1'b1;
  end
`endif

  always_comb begin
    dataOut = '0;
    if (w_c_hit) begin
      for (int j = 0; j < CL; j++)
        dataOut[j*BITS_C +: BITS_C] = w_c[w_c_row][{w_c_half, LW'(j)}];
    end
`ifdef TPU_STATUS_EN
    else if (addr == LS)   dataOut = DATAW'(w_busy);
    else if (addr == LCNT) dataOut = DATAW'(r_done_cnt);
`endif
  end
endmodule

// File: tb/tb_tpu_v1.sv
// Self-checking bench for tpu_v1: matrix-level reference model plus literal pins.
module tb_tpu_v1;
  logic        clk = 1'b0;
  logic        rst_n, r_w;
  logic [15:0] addr;
  logic [63:0] dataIn, dataOut;

  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0, mbusy = 1'b0;
  int ma[8][8], mb[8][8];
  logic [15:0] mc[8][8];
  int unsigned mcount;

  tpu_v1 dut (.clk(clk), .rst_n(rst_n), .r_w(r_w), .addr(addr), .dataIn(dataIn), .dataOut(dataOut));

  always #5 clk = ~clk;

  function automatic logic [63:0] mread(input logic [15:0] a);
    logic [63:0] v = '0;
    if (a >= 16'h300 && a < 16'h380 && a[2:0] == 3'b0) begin
      for (int j = 0; j < 4; j++) v[16*j +: 16] = mc[a[6:4]][(a[3] ? 4 : 0) + j];
    end
`ifdef TPU_STATUS_EN
    else if (a == 16'h408) v = {32'b0, mcount};
`endif
    return v;
  endfunction

  function automatic void mwrite(input logic [15:0] a, input logic [63:0] d);
    if (a >= 16'h100 && a < 16'h140 && a[2:0] == 3'b0)
      for (int k = 0; k < 8; k++) ma[a[5:3]][k] = $signed(d[8*k +: 8]);
    if (a >= 16'h200 && a < 16'h240 && a[2:0] == 3'b0)
      for (int k = 0; k < 8; k++) mb[a[5:3]][k] = $signed(d[8*k +: 8]);
    if (a >= 16'h300 && a < 16'h380 && a[2:0] == 3'b0)
      for (int j = 0; j < 4; j++) mc[a[6:4]][(a[3] ? 4 : 0) + j] = d[16*j +: 16];
  endfunction

  function automatic void mreset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = 0; mb[r][c] = 0; mc[r][c] = '0;
      end
    mcount = 0;
  endfunction

  function automatic void mmatmul();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int s = int'(mc[r][c]);
        for (int k = 0; k < 8; k++) s += ma[r][k] * mb[k][c];
        mc[r][c] = 16'(s);
      end
  endfunction

  // Every idle-time read cycle is compared against the model.
  always @(negedge clk) begin
    if (chk_en && !r_w) begin
      n_chk++;
      if (dataOut !== mread(addr)) begin
        n_err++;
        $display("FAIL model_rd addr=%h got=%h exp=%h", addr, dataOut, mread(addr));
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    r_w = 1'b1; addr = a; dataIn = d;
    if (!mbusy) mwrite(a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    @(posedge clk); #1;
    r_w = 1'b0; addr = a;
  endtask

  task automatic rd_exp(input logic [15:0] a, input logic [63:0] exp, input string nm);
    rd(a);
    @(negedge clk);
    n_chk++;
    if (dataOut !== exp) begin
      n_err++;
      $display("FAIL %s addr=%h got=%h exp=%h", nm, a, dataOut, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) rd(16'h0);
  endtask

  task automatic read_all_c();
    for (int i = 0; i < 16; i++) rd(16'h300 + 16'(8*i));
  endtask

  task automatic zero_c();
    for (int i = 0; i < 16; i++) wr(16'h300 + 16'(8*i), 64'h0);
  endtask

  task automatic rand_ab();
    for (int i = 0; i < 8; i++) wr(16'h100 + 16'(8*i), {$urandom, $urandom});
    for (int i = 0; i < 8; i++) wr(16'h200 + 16'(8*i), {$urandom, $urandom});
  endtask

  // Start, optionally poke writes that must be ignored while busy, then wait out the latency.
  task automatic run_compute(input bit poke);
    wr(16'h400, {$urandom, $urandom});
    mmatmul();
    mcount++;
    mbusy = 1'b1; chk_en = 1'b0;
    if (poke) begin
      wr(16'h300, {$urandom, $urandom});
      wr(16'h108, {$urandom, $urandom});
      wr(16'h400, 64'h0);
    end
    idle(30);
    mbusy = 1'b0; chk_en = 1'b1;
  endtask

  initial begin
    logic [63:0] d;
    rst_n = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
    mreset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) rd_exp(16'h300 + 16'(8*i), 64'h0, "rst_c");
    rd(16'h400); rd(16'h408); rd(16'h100);

    for (int r = 0; r < 8; r++) begin
      wr(16'h300 + 16'(16*r), 64'h0123_4567_89AB_CDEF);
      wr(16'h308 + 16'(16*r), 64'h0);
    end
    rd_exp(16'h300, 64'h0123_4567_89AB_CDEF, "c_wr_lo");
    rd_exp(16'h378, 64'h0, "c_wr_hi");
    read_all_c();

    for (int i = 0; i < 8; i++) begin
      wr(16'h100 + 16'(8*i), 64'h1 << (8*i));
      for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(i*8 + k);
      wr(16'h200 + 16'(8*i), d);
    end
    zero_c();
    run_compute(1'b0);
    rd_exp(16'h320, 64'h0013_0012_0011_0010, "ident_r2");
    rd_exp(16'h378, 64'h003F_003E_003D_003C, "ident_r7");
    read_all_c();
    rd(16'h100); rd(16'h208); rd(16'h400);

    for (int i = 0; i < 8; i++) wr(16'h100 + 16'(8*i), {8{8'h7F}});
    for (int i = 0; i < 8; i++) wr(16'h200 + 16'(8*i), {8{8'h80}});
    zero_c();
    run_compute(1'b0);
    rd_exp(16'h300, 64'h0400_0400_0400_0400, "wrap_lo");
    rd_exp(16'h378, 64'h0400_0400_0400_0400, "wrap_hi");
    read_all_c();

    for (int it = 0; it < 10; it++) begin
      rand_ab();
      if (it % 3 == 2) for (int i = 0; i < 16; i++) wr(16'h300 + 16'(8*i), {$urandom, $urandom});
      else zero_c();
      run_compute(it % 2 == 1);
      read_all_c();
      if (it == 4) begin
        run_compute(1'b0);
        read_all_c();
      end
      for (int i = 0; i < 4; i++) rd(16'($urandom_range(0, 16'hFFFF)));
    end

    rand_ab();
    wr(16'h400, 64'h0);
    mbusy = 1'b1; chk_en = 1'b0;
    idle(5);
    rst_n = 1'b0;
    mreset();
    mbusy = 1'b0; chk_en = 1'b1;
    rd(16'h300); rd(16'h378);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) rd_exp(16'h300 + 16'(8*i), 64'h0, "midrst_c");
    rd(16'h400); rd(16'h408);
    wr(16'h300, 64'hDEAD_BEEF_1234_5678);
    rd_exp(16'h300, 64'hDEAD_BEEF_1234_5678, "post_rst_wr");
    read_all_c();
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
